mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// - MEM stage of the 5-stage LoongArch pipeline, between exe_stage and wb_stage.
// - Holds the EX-stage bundle and waits for the data-SRAM response of a load/store issued in EX.
// - For loads, extracts, aligns and sign/zero-extends the read data.
// - Drives ms_to_ws_bus {gr_we, dest, final_result, pc} to WB, and forwarding/stall info to ID.
// PARAMETERS
// - none. Widths are fixed macros in mycpu.h: `ES_TO_MS_BUS_WD = 75, `MS_TO_WS_BUS_WD = 70.
// PORTS
// - clk             in   1   clock
// - reset           in   1   synchronous, active-high
// - es_to_ms_valid  in   1   EX holds a valid instruction for MEM
// - es_to_ms_bus    in   75  {mem_op[74:72], mem_req[71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
// - ms_allowin      out  1   MEM can accept a new instruction this cycle
// - ms_to_ws_valid  out  1   MEM presents a finished instruction to WB
// - ms_to_ws_bus    out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
// - ws_allowin      in   1   WB accepts this cycle
// - data_sram_data_ok in 1   one-cycle pulse: response for the oldest outstanding request
// - data_sram_rdata in   32  read data, valid with data_ok
// - ms_to_ds_dest   out  5   forwarding dest; 0 when not writing
// - ms_to_ds_result out  32  forwarding value (final_result)
// - ms_to_ds_load_wait out 1 MEM load result not yet available; ID must stall on a dest match
// BEHAVIOUR
// - Reset: ms_valid = 0, state = IDLE, buffer valid = 0. All outputs are then 0 or
//   don't-care gated by ms_valid. ms_allowin = 1.
// - Handshake:
//   - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
//   - ms_to_ws_valid = ms_valid && ms_ready_go.
//   - On ms_allowin: ms_valid <= es_to_ms_valid.
//   - On es_to_ms_valid && ms_allowin: latch the bus into ms_bus_r.
// - mem_req = 1: EX issued a request that the SRAM accepted (load or store). One data_ok is owed.
// - FSM, evaluated only while ms_valid:
//   - IDLE: on latching an instruction with mem_req = 1 -> WAIT. Otherwise stay; ms_ready_go = 1.
//   - WAIT: ms_ready_go = data_ok. On data_ok with ws_allowin = 1 -> IDLE; the instruction leaves
//     the same cycle (0-cycle data path, rdata used combinationally). On data_ok with
//     ws_allowin = 0: capture rdata into rdata_buf -> HOLD.
//   - HOLD: ms_ready_go = 1 and result comes from rdata_buf. On ws_allowin -> IDLE,
//     or -> WAIT if a new mem_req instruction is latched the same cycle.
//   - Leave and refill in one cycle: the next state follows the incoming instruction's mem_req.
// - data_ok arriving in IDLE, or while !ms_valid, is ignored (protocol violation; the bench asserts it never happens).
// - final_result = res_from_mem ? load_data : alu_result. Stores end with final_result = alu_result
//   and gr_we = 0 from EX.
// - Load extraction, using addr[1:0] = alu_result[1:0]:
//   - 000 ld.w: the word.
//   - 001 ld.b: byte addr[1:0], sign-extended.
//   - 010 ld.h: half addr[1], sign-extended.
//   - 011 ld.bu: byte, zero-extended.
//   - 100 ld.hu: half, zero-extended.
//   - 101-111: treated as ld.w.
//   - Misalignment is already handled upstream; addr[0] is ignored for halves.
// - Forwarding:
//   - ms_to_ds_dest = dest & {5{ms_valid && gr_we}}.
//   - ms_to_ds_load_wait = ms_valid && res_from_mem && !ms_ready_go.
// - Synchronous reset mid-WAIT/HOLD returns to IDLE and drops the instruction. The memory side
//   is reset in the same cycle, so no stale data_ok is expected.
// STRUCTURE
// - mycpu.h: bus width macros, MEM_OP_* encodings, and field bit positions shared with exe_stage/wb_stage.
// - Sub-module load_align (combinational): inputs mem_op, addr[1:0], rdata; output 32-bit load_data.
// - FSM and buffer stay in mem_stage.
// TESTING
// - ALU op: bus {mem_req=0, gr_we=1, dest=5, alu=0x1234}, ws_allowin=1 -> next cycle ms_to_ws_valid=1,
//   final_result=0x1234, ms_to_ds_dest=5, load_wait=0.
// - ld.b addr=...3, data_ok in 2nd MEM cycle with rdata=0x80FF_0000 -> load_wait=1 in cycle 1;
//   cycle 2 final_result=0xFFFF_FF80.
// - ld.hu addr=...2, rdata=0x8001_7FFF -> 0x0000_8001. ld.h addr=...0 -> 0x0000_7FFF.
// - data_ok with ws_allowin=0 for 3 cycles, rdata=0xDEAD_BEEF -> state HOLD, ms_allowin=0.
//   When ws_allowin rises: final_result=0xDEAD_BEEF, exactly one ms_to_ws_valid beat.
// - Back-to-back ld.w pair, data_ok on consecutive cycles, ws_allowin=1 -> two WB results in order,
//   no bubble between them, state IDLE->WAIT->WAIT->IDLE.
// - reset asserted while in WAIT -> next cycle ms_valid=0, ms_allowin=1, ms_to_ds_dest=0, no WB beat.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load-op encodings,
// the EX->MEM / MEM->WB bundle layouts and the MEM wait-FSM states.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 75;
    localparam int MS_TO_WS_BUS_WD = 70;

    // mem_op encodings; 101..111 fall back to a plain word load.
    localparam logic [2:0] MEM_OP_W  = 3'b000;
    localparam logic [2:0] MEM_OP_B  = 3'b001;
    localparam logic [2:0] MEM_OP_H  = 3'b010;
    localparam logic [2:0] MEM_OP_BU = 3'b011;
    localparam logic [2:0] MEM_OP_HU = 3'b100;

    // Field order matches the flat 75-bit bus, MSB first.
    typedef struct packed {
        logic [2:0]  mem_op;
        logic        mem_req;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no outstanding response (non-memory op or empty)
        ST_WAIT = 2'd1,   // data_ok still owed for the held instruction
        ST_HOLD = 2'd2    // response arrived while WB stalled; data parked in buffer
    } ms_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: selects the addressed byte/half of the
// SRAM read word and sign- or zero-extends it.
//   mem_op    in  3   load kind (MEM_OP_*)
//   addr      in  2   low address bits; addr[0] is ignored for halves
//   rdata     in  32  raw read word
//   load_data out 32  aligned, extended result
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (mem_op)
            MEM_OP_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_H:  load_data = {{16{half_sel[15]}}, half_sel};
            MEM_OP_BU: load_data = {24'd0, byte_sel};
            MEM_OP_HU: load_data = {16'd0, half_sel};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline. Holds the EX bundle, waits for the
// data-SRAM response owed by a load/store issued in EX, aligns load data
// and hands {gr_we, dest, final_result, pc} to WB. Also feeds ID with the
// forwarding destination/value and a load-wait stall hint.
//   clk, reset                     clock, synchronous active-high reset
//   es_to_ms_valid/es_to_ms_bus    incoming instruction from EX
//   ms_allowin                     MEM can accept this cycle
//   ms_to_ws_valid/ms_to_ws_bus    finished instruction to WB
//   ws_allowin                     WB accepts this cycle
//   data_sram_data_ok/rdata        response pulse + read data
//   ms_to_ds_dest/result/load_wait forwarding and stall info to ID
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       ws_allowin,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [4:0]                 ms_to_ds_dest,
    output logic [31:0]                ms_to_ds_result,
    output logic                       ms_to_ds_load_wait
);

    es_to_ms_t  in_bus;
    es_to_ms_t  ms_bus_q, ms_bus_d;
    logic       ms_valid_q, ms_valid_d;
    ms_state_e  state_q, state_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        ms_ready_go;
    logic [31:0] rdata_src;
    logic [31:0] load_data;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;

    assign in_bus = es_to_ms_bus;

    always_comb begin
        // WAIT is only ever entered with a valid instruction, so the state
        // alone decides readiness.
        ms_ready_go = (state_q == ST_WAIT) ? data_sram_data_ok : 1'b1;
        ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);

        ms_valid_d  = ms_valid_q;
        ms_bus_d    = ms_bus_q;
        state_d     = state_q;
        rdata_buf_d = rdata_buf_q;

        if (ms_allowin) begin
            // Covers both plain fill and leave-and-refill: the next state
            // follows the incoming instruction only.
            ms_valid_d = es_to_ms_valid;
            if (es_to_ms_valid) begin
                ms_bus_d = in_bus;
            end
            state_d = (es_to_ms_valid && in_bus.mem_req) ? ST_WAIT : ST_IDLE;
        end else if (state_q == ST_WAIT && data_sram_data_ok) begin
            // Response arrived but WB is stalled: the SRAM will not repeat it.
            state_d     = ST_HOLD;
            rdata_buf_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            ms_bus_q    <= '0;
            state_q     <= ST_IDLE;
            rdata_buf_q <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            ms_bus_q    <= ms_bus_d;
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // In WAIT the response is used the cycle it arrives; HOLD replays the buffer.
    assign rdata_src = (state_q == ST_HOLD) ? rdata_buf_q : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .mem_op    (ms_bus_q.mem_op),
        .addr      (ms_bus_q.alu_result[1:0]),
        .rdata     (rdata_src),
        .load_data (load_data)
    );

    assign final_result = ms_bus_q.res_from_mem ? load_data : ms_bus_q.alu_result;

    always_comb begin
        ws_bus.gr_we        = ms_bus_q.gr_we;
        ws_bus.dest         = ms_bus_q.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = ms_bus_q.pc;
    end

    assign ms_to_ws_bus       = ws_bus;
    assign ms_to_ws_valid     = ms_valid_q && ms_ready_go;
    assign ms_to_ds_dest      = ms_bus_q.dest & {5{ms_valid_q && ms_bus_q.gr_we}};
    assign ms_to_ds_result    = final_result;
    assign ms_to_ds_load_wait = ms_valid_q && ms_bus_q.res_from_mem && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        ws_allowin;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [4:0]  ms_to_ds_dest;
    logic [31:0] ms_to_ds_result;
    logic        ms_to_ds_load_wait;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allowin        (ws_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ds_dest     (ms_to_ds_dest),
        .ms_to_ds_result   (ms_to_ds_result),
        .ms_to_ds_load_wait(ms_to_ds_load_wait)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction sitting in MEM, and whether its
    // memory response has already been received.
    logic      model_on = 1'b0;
    logic      m_valid  = 1'b0;
    es_to_ms_t m_bus    = '0;
    logic      m_have   = 1'b0;
    logic [31:0] m_data = '0;

    // Outputs observed in the most recent cycle.
    logic        o_allow, o_wsv, o_lw;
    logic [4:0]  o_dest;
    logic [31:0] o_res;
    ms_to_ws_t   o_bus;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a)) & 32'hFF;
        h = (rd >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic es_to_ms_t mk(input logic [2:0] op, input logic req, input logic res,
                                     input logic we, input logic [4:0] d,
                                     input logic [31:0] alu, input logic [31:0] pc);
        es_to_ms_t b;
        b.mem_op = op; b.mem_req = req; b.res_from_mem = res; b.gr_we = we;
        b.dest = d; b.alu_result = alu; b.pc = pc;
        return b;
    endfunction

    // One clock cycle: drive, sample, compare against the model, advance.
    task automatic cyc(input logic rst, input logic ev, input es_to_ms_t b, input logic wa,
                       input logic dok, input logic [31:0] rd);
        logic ready, e_allow;
        logic [31:0] e_res, data;
        reset = rst; es_to_ms_valid = ev; es_to_ms_bus = b; ws_allowin = wa;
        data_sram_data_ok = dok; data_sram_rdata = rd;
        #2;
        o_allow = ms_allowin; o_wsv = ms_to_ws_valid; o_lw = ms_to_ds_load_wait;
        o_dest = ms_to_ds_dest; o_res = ms_to_ds_result; o_bus = ms_to_ws_bus;

        ready   = m_valid && (!m_bus.mem_req || m_have || dok);
        e_allow = !m_valid || (ready && wa);
        data    = m_have ? m_data : rd;
        e_res   = m_bus.res_from_mem ? ref_load(m_bus.mem_op, m_bus.alu_result[1:0], data)
                                     : m_bus.alu_result;
        if (model_on) begin
            chk("allowin", {31'd0, o_allow}, {31'd0, e_allow});
            chk("ws_valid", {31'd0, o_wsv}, {31'd0, ready});
            chk("load_wait", {31'd0, o_lw}, {31'd0, m_valid && m_bus.res_from_mem && !ready});
            chk("fwd_dest", {27'd0, o_dest}, {27'd0, (m_valid && m_bus.gr_we) ? m_bus.dest : 5'd0});
            if (ready) begin
                chk("fwd_result", o_res, e_res);
                chk("ws_result", o_bus.final_result, e_res);
                chk("ws_pc", o_bus.pc, m_bus.pc);
                chk("ws_dest_we", {26'd0, o_bus.gr_we, o_bus.dest}, {26'd0, m_bus.gr_we, m_bus.dest});
            end
        end

        if (rst) begin
            m_valid = 1'b0; m_have = 1'b0;
        end else if (e_allow) begin
            m_valid = ev; m_have = 1'b0;
            if (ev) m_bus = b;
        end else if (m_valid && m_bus.mem_req && !m_have && dok) begin
            m_have = 1'b1; m_data = rd;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  a;
        logic [31:0] rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];
    es_to_ms_t zb;

    initial begin
        zb = '0;
        tbl[0] = '{3'd1, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
        tbl[1] = '{3'd4, 2'd2, 32'h8001_7FFF, 32'h0000_8001};
        tbl[2] = '{3'd2, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF};
        tbl[3] = '{3'd0, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D};
        tbl[4] = '{3'd3, 2'd1, 32'h1234_56F0, 32'h0000_0056};
        tbl[5] = '{3'd3, 2'd0, 32'h1234_56F0, 32'h0000_00F0};
        tbl[6] = '{3'd1, 2'd0, 32'h1234_56F0, 32'hFFFF_FFF0};
        tbl[7] = '{3'd2, 2'd3, 32'h8001_7FFF, 32'hFFFF_8001};
        tbl[8] = '{3'd5, 2'd2, 32'hA5A5_0F0F, 32'hA5A5_0F0F};
        tbl[9] = '{3'd7, 2'd1, 32'h0102_0304, 32'h0102_0304};

        // Reset
        cyc(1, 0, zb, 1, 0, 0);
        cyc(1, 0, zb, 1, 0, 0);
        model_on = 1'b1;
        cyc(0, 0, zb, 1, 0, 0);
        chk("rst_allowin", {31'd0, o_allow}, 32'd1);
        chk("rst_wsv", {31'd0, o_wsv}, 32'd0);
        chk("rst_dest", {27'd0, o_dest}, 32'd0);
        chk("rst_lw", {31'd0, o_lw}, 32'd0);

        // ALU op passes straight through
        cyc(0, 1, mk(3'd0, 0, 0, 1, 5'd5, 32'h1234, 32'h1C00_0000), 1, 0, 0);
        cyc(0, 0, zb, 1, 0, 0);
        chk("alu_wsv", {31'd0, o_wsv}, 32'd1);
        chk("alu_res", o_res, 32'h1234);
        chk("alu_dest", {27'd0, o_dest}, 32'd5);
        chk("alu_lw", {31'd0, o_lw}, 32'd0);

        // ld.b with response in the 2nd MEM cycle
        cyc(0, 1, mk(3'd1, 1, 1, 1, 5'd7, 32'h0000_2003, 32'h1C00_0010), 1, 0, 0);
        cyc(0, 0, zb, 1, 0, 0);
        chk("ldb_lw1", {31'd0, o_lw}, 32'd1);
        chk("ldb_wsv1", {31'd0, o_wsv}, 32'd0);
        chk("ldb_allow1", {31'd0, o_allow}, 32'd0);
        cyc(0, 0, zb, 1, 1, 32'h80FF_0000);
        chk("ldb_wsv2", {31'd0, o_wsv}, 32'd1);
        chk("ldb_res2", o_res, 32'hFFFF_FF80);
        cyc(0, 0, zb, 1, 0, 0);

        // Load extraction table
        foreach (tbl[i]) begin
            cyc(0, 1, mk(tbl[i].op, 1, 1, 1, 5'd3, 32'h1000 + {30'd0, tbl[i].a}, 32'h100 + i), 1, 0, 0);
            cyc(0, 0, zb, 1, 1, tbl[i].rd);
            chk("tbl_wsv", {31'd0, o_wsv}, 32'd1);
            chk("tbl_res", o_res, tbl[i].exp);
        end
        cyc(0, 0, zb, 1, 0, 0);

        // Response while WB stalled -> buffered, one beat when WB opens
        cyc(0, 1, mk(3'd0, 1, 1, 1, 5'd9, 32'h2000, 32'h40), 1, 0, 0);
        cyc(0, 0, zb, 0, 1, 32'hDEAD_BEEF);
        chk("hold_wsv0", {31'd0, o_wsv}, 32'd1);
        chk("hold_allow0", {31'd0, o_allow}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, zb, 0, 0, 32'h0);
            chk("hold_allow", {31'd0, o_allow}, 32'd0);
            chk("hold_lw", {31'd0, o_lw}, 32'd0);
            chk("hold_res", o_res, 32'hDEAD_BEEF);
        end
        cyc(0, 0, zb, 1, 0, 32'h0);
        chk("hold_beat", {31'd0, o_wsv && ws_allowin}, 32'd1);
        chk("hold_res_out", o_res, 32'hDEAD_BEEF);
        cyc(0, 0, zb, 1, 0, 0);
        chk("hold_single", {31'd0, o_wsv}, 32'd0);

        // Back-to-back ld.w, no bubble
        cyc(0, 1, mk(3'd0, 1, 1, 1, 5'd1, 32'h100, 32'hA0), 1, 0, 0);
        cyc(0, 1, mk(3'd0, 1, 1, 1, 5'd2, 32'h104, 32'hA4), 1, 1, 32'h1111_1111);
        chk("b2b_wsv0", {31'd0, o_wsv}, 32'd1);
        chk("b2b_res0", o_res, 32'h1111_1111);
        chk("b2b_pc0", o_bus.pc, 32'hA0);
        cyc(0, 0, zb, 1, 1, 32'h2222_2222);
        chk("b2b_wsv1", {31'd0, o_wsv}, 32'd1);
        chk("b2b_res1", o_res, 32'h2222_2222);
        chk("b2b_pc1", o_bus.pc, 32'hA4);
        cyc(0, 0, zb, 1, 0, 0);
        chk("b2b_end", {31'd0, o_wsv}, 32'd0);

        // Reset while waiting
        cyc(0, 1, mk(3'd0, 1, 1, 1, 5'd4, 32'h300, 32'hB0), 1, 0, 0);
        cyc(1, 0, zb, 1, 0, 0);
        cyc(0, 0, zb, 1, 0, 0);
        chk("rstw_allow", {31'd0, o_allow}, 32'd1);
        chk("rstw_wsv", {31'd0, o_wsv}, 32'd0);
        chk("rstw_dest", {27'd0, o_dest}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            es_to_ms_t rb;
            logic ev, wa, dok, rst;
            int kind;
            kind = $urandom_range(0, 2);
            rb = mk(3'($urandom_range(0, 7)), kind != 0, kind == 1, kind != 2,
                    5'($urandom), $urandom, $urandom);
            ev  = ($urandom_range(0, 3) != 0);
            wa  = ($urandom_range(0, 3) != 0);
            dok = (m_valid && m_bus.mem_req && !m_have) ? 1'($urandom_range(0, 1)) : 1'b0;
            rst = ($urandom_range(0, 99) == 0);
            cyc(rst, ev, rb, wa, dok, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
